// File: rtl/riscv_wb_arbiter.sv
// rtl/riscv_wb_arbiter.sv - ALU/LSU writeback arbiter with registered regfile write stage and load scoreboard
module riscv_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_alu_valid,
  output logic            o_alu_ready,
  input  logic [4:0]      i_alu_rd_addr,
  input  logic [XLEN-1:0] i_alu_rd_data,
  input  logic            i_lsu_valid,
  output logic            o_lsu_ready,
  input  logic [4:0]      i_lsu_rd_addr,
  input  logic [XLEN-1:0] i_lsu_rd_data,
  input  logic            i_load_issue,
  input  logic [4:0]      i_load_rd_addr,
  input  logic [4:0]      i_rs1_addr,
  input  logic [4:0]      i_rs2_addr,
  output logic            o_rs1_busy,
  output logic            o_rs2_busy,
  output logic            o_regfile_rd_wen,
  output logic [4:0]      o_regfile_rd_addr,
  output logic [XLEN-1:0] o_regfile_rd_data
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  logic [3:0]  starve_cnt;
  logic        stage_src;
  logic [31:0] busy_q;
  logic        forced;
  logic        alu_grant;
  logic        lsu_grant;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  // Forced mode lets a waiting LSU override the ALU once it has lost STARVE_MAX times in a row
  assign forced    = (starve_cnt == CNT_MAX);
  assign lsu_grant = !i_rst && i_lsu_valid && (forced || !i_alu_valid);
  assign alu_grant = !i_rst && i_alu_valid && !(forced && i_lsu_valid);

  assign o_alu_ready = alu_grant;
  assign o_lsu_ready = lsu_grant;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_cnt <= 4'd0;
    end else if (!i_lsu_valid || lsu_grant) begin
      starve_cnt <= 4'd0;
    end else if (alu_grant && starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_regfile_rd_wen  <= 1'b0;
      o_regfile_rd_addr <= 5'd0;
      o_regfile_rd_data <= '0;
      stage_src         <= 1'b0;
    end else if (lsu_grant) begin
      o_regfile_rd_wen  <= (i_lsu_rd_addr != 5'd0);
      o_regfile_rd_addr <= i_lsu_rd_addr;
      o_regfile_rd_data <= i_lsu_rd_data;
      stage_src         <= 1'b1;
    end else if (alu_grant) begin
      o_regfile_rd_wen  <= (i_alu_rd_addr != 5'd0);
      o_regfile_rd_addr <= i_alu_rd_addr;
      o_regfile_rd_data <= i_alu_rd_data;
      stage_src         <= 1'b0;
    end else begin
      o_regfile_rd_wen  <= 1'b0;
    end
  end

  // A new load to the register being committed keeps it busy: set is applied after clear
  assign set_mask = (i_load_issue && i_load_rd_addr != 5'd0) ? (32'd1 << i_load_rd_addr) : 32'd0;
  assign clr_mask = (o_regfile_rd_wen && stage_src) ? (32'd1 << o_regfile_rd_addr) : 32'd0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy_q <= 32'd0;
    end else begin
      busy_q <= ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
    end
  end

  assign o_rs1_busy = busy_q[i_rs1_addr];
  assign o_rs2_busy = busy_q[i_rs2_addr];

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// tb/tb_riscv_wb_arbiter.sv - directed self-checking bench for riscv_wb_arbiter
module tb_riscv_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd_addr;
  logic [31:0] alu_rd_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd_addr;
  logic [31:0] lsu_rd_data;
  logic        load_issue;
  logic [4:0]  load_rd_addr, rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  riscv_wb_arbiter #(.XLEN(32), .STARVE_MAX(3)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_alu_valid(alu_valid), .o_alu_ready(alu_ready),
    .i_alu_rd_addr(alu_rd_addr), .i_alu_rd_data(alu_rd_data),
    .i_lsu_valid(lsu_valid), .o_lsu_ready(lsu_ready),
    .i_lsu_rd_addr(lsu_rd_addr), .i_lsu_rd_data(lsu_rd_data),
    .i_load_issue(load_issue), .i_load_rd_addr(load_rd_addr),
    .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
    .o_rs1_busy(rs1_busy), .o_rs2_busy(rs2_busy),
    .o_regfile_rd_wen(wen), .o_regfile_rd_addr(waddr), .o_regfile_rd_data(wdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Both requesters valid for n cycles; expected pattern ALU,ALU,ALU,LSU repeating from a cleared counter
  task automatic contend(input string tag, input int n);
    alu_valid = 1; alu_rd_addr = 5'd1; alu_rd_data = 32'h11;
    lsu_valid = 1; lsu_rd_addr = 5'd2; lsu_rd_data = 32'h22;
    for (int i = 0; i < n; i++) begin
      #1;
      check({tag, "_alu_rdy"}, {31'd0, alu_ready}, {31'd0, (i % 4) != 3});
      check({tag, "_lsu_rdy"}, {31'd0, lsu_ready}, {31'd0, (i % 4) == 3});
      tick();
      check({tag, "_waddr"}, {27'd0, waddr}, ((i % 4) == 3) ? 32'd2 : 32'd1);
    end
    alu_valid = 0; lsu_valid = 0;
  endtask

  initial begin
    rst = 1; alu_valid = 1; alu_rd_addr = 5'd4; alu_rd_data = 32'h44;
    lsu_valid = 0; lsu_rd_addr = 0; lsu_rd_data = 0;
    load_issue = 0; load_rd_addr = 0; rs1_addr = 0; rs2_addr = 0;
    tick(); tick();
    check("rst_alu_rdy", {31'd0, alu_ready}, 32'd0);
    check("rst_wen", {31'd0, wen}, 32'd0);
    check("rst_addr", {27'd0, waddr}, 32'd0);
    check("rst_data", wdata, 32'd0);
    check("rst_busy1", {31'd0, rs1_busy}, 32'd0);
    rst = 0; alu_valid = 0;
    tick();

    // T1 ALU only
    alu_valid = 1; alu_rd_addr = 5'd5; alu_rd_data = 32'hA5;
    #1;
    check("t1_alu_rdy", {31'd0, alu_ready}, 32'd1);
    check("t1_lsu_rdy", {31'd0, lsu_ready}, 32'd0);
    tick();
    alu_valid = 0;
    check("t1_wen", {31'd0, wen}, 32'd1);
    check("t1_addr", {27'd0, waddr}, 32'd5);
    check("t1_data", wdata, 32'hA5);
    tick();
    check("t1_idle_wen", {31'd0, wen}, 32'd0);
    check("t1_hold_addr", {27'd0, waddr}, 32'd5);
    check("t1_hold_data", wdata, 32'hA5);

    // T2 contention
    contend("t2", 8);

    // T3 x0 load write is consumed but never written
    lsu_valid = 1; lsu_rd_addr = 5'd0; lsu_rd_data = 32'hFFFF_FFFF;
    #1;
    check("t3_lsu_rdy", {31'd0, lsu_ready}, 32'd1);
    tick();
    lsu_valid = 0;
    check("t3_wen", {31'd0, wen}, 32'd0);

    // T4 scoreboard set/clear, and ALU writes leave it alone
    rs1_addr = 5'd7; rs2_addr = 5'd9;
    load_issue = 1; load_rd_addr = 5'd7;
    #1;
    check("t4_busy_pre", {31'd0, rs1_busy}, 32'd0);
    tick();
    load_issue = 1; load_rd_addr = 5'd9;
    check("t4_busy_set", {31'd0, rs1_busy}, 32'd1);
    tick();
    load_issue = 0;
    alu_valid = 1; alu_rd_addr = 5'd9; alu_rd_data = 32'h99;
    check("t4_busy9", {31'd0, rs2_busy}, 32'd1);
    tick();
    alu_valid = 0;
    lsu_valid = 1; lsu_rd_addr = 5'd7; lsu_rd_data = 32'h77;
    check("t4_busy_grant", {31'd0, rs1_busy}, 32'd1);
    tick();
    lsu_valid = 0;
    check("t4_wen", {31'd0, wen}, 32'd1);
    check("t4_waddr", {27'd0, waddr}, 32'd7);
    check("t4_busy_wr", {31'd0, rs1_busy}, 32'd1);
    check("t4_alu_no_clr", {31'd0, rs2_busy}, 32'd1);
    tick();
    check("t4_busy_clr", {31'd0, rs1_busy}, 32'd0);
    check("t4_busy9_kept", {31'd0, rs2_busy}, 32'd1);

    // T5 issue and commit of x7 in the same cycle: set wins
    load_issue = 1; load_rd_addr = 5'd7;
    tick();
    load_issue = 0;
    lsu_valid = 1; lsu_rd_addr = 5'd7; lsu_rd_data = 32'h78;
    tick();
    lsu_valid = 0;
    load_issue = 1; load_rd_addr = 5'd7;
    check("t5_wen", {31'd0, wen}, 32'd1);
    tick();
    load_issue = 0;
    check("t5_busy_kept", {31'd0, rs1_busy}, 32'd1);
    tick();
    check("t5_busy_still", {31'd0, rs1_busy}, 32'd1);

    // T6 reset drops an uncommitted grant, clears busy bits and the starvation count
    alu_valid = 1; alu_rd_addr = 5'd1; alu_rd_data = 32'h11;
    lsu_valid = 1; lsu_rd_addr = 5'd2; lsu_rd_data = 32'h22;
    tick(); tick();
    alu_rd_addr = 5'd3; alu_rd_data = 32'h33;
    tick();
    rst = 1;
    #1;
    check("t6_alu_rdy", {31'd0, alu_ready}, 32'd0);
    check("t6_lsu_rdy", {31'd0, lsu_ready}, 32'd0);
    tick();
    rst = 0;
    check("t6_wen", {31'd0, wen}, 32'd0);
    check("t6_addr", {27'd0, waddr}, 32'd0);
    check("t6_data", wdata, 32'd0);
    check("t6_busy1", {31'd0, rs1_busy}, 32'd0);
    check("t6_busy2", {31'd0, rs2_busy}, 32'd0);
    contend("t6_cnt", 4);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
